// File: rtl/proc_pkg.sv
// Shared definitions for the quad-core memory-side controllers.
// Holds the core/address/data sizes and the arbiter FSM state encoding.
package proc_pkg;

    localparam int NUM_CORES = 4;
    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } state_e;

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin grant picker, purely combinational.
// Ports: req_i (4 requests), last_i (last granted id),
//        gnt_id_o (winning id), gnt_valid_o (any request present).
module rr_arbiter4 (
    input  logic [3:0] req_i,
    input  logic [1:0] last_i,
    output logic [1:0] gnt_id_o,
    output logic       gnt_valid_o
);

    logic [1:0] cand;

    // Walk from the farthest candidate (last itself) to the nearest
    // (last+1) so the closest set bit after last overwrites the rest.
    always_comb begin
        gnt_id_o    = 2'd0;
        gnt_valid_o = |req_i;
        cand        = 2'd0;
        for (int i = 4; i >= 1; i--) begin
            cand = last_i + 2'(i);
            if (req_i[cand]) begin
                gnt_id_o = cand;
            end
        end
    end

endmodule

// File: rtl/im_fetch_arbiter.sv
// Round-robin, latency-aware sharer of the single-port instruction RAM.
// Ports: clk, reset (sync, active-high); core_en/req/req_addr from cores;
//        ins_addr/ins_read/ins_data to the RAM; resp_valid/resp_data back
//        to the cores; grant_id (core being served), busy (not IDLE).
module im_fetch_arbiter #(
    parameter int NUM_CORES = proc_pkg::NUM_CORES,
    parameter int ADDR_W    = proc_pkg::ADDR_W,
    parameter int DATA_W    = proc_pkg::DATA_W,
    parameter int MEM_LAT   = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CORES-1:0]          core_en,
    input  logic [NUM_CORES-1:0]          req,
    input  logic [NUM_CORES*ADDR_W-1:0]   req_addr,
    output logic [ADDR_W-1:0]             ins_addr,
    output logic                          ins_read,
    input  logic [DATA_W-1:0]             ins_data,
    output logic [NUM_CORES-1:0]          resp_valid,
    output logic [DATA_W-1:0]             resp_data,
    output logic [1:0]                    grant_id,
    output logic                          busy
);

    import proc_pkg::*;

    localparam int CNT_W = $clog2(MEM_LAT + 1);

    state_e             state_q, state_d;
    logic [1:0]         last_q, last_d;
    logic [1:0]         id_q, id_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [NUM_CORES-1:0] elig;
    logic [1:0]           gnt_id;
    logic                 gnt_valid;

    assign elig = req & core_en;

    rr_arbiter4 u_rr (
        .req_i       (elig),
        .last_i      (last_q),
        .gnt_id_o    (gnt_id),
        .gnt_valid_o (gnt_valid)
    );

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 2'd3;
            id_q    <= 2'd0;
            addr_q  <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (gnt_valid) state_d = ISSUE;
            ISSUE: state_d = WAIT;
            WAIT:  if (cnt_q == '0) state_d = RESP;
            RESP:  state_d = IDLE;
        endcase
    end

    // Datapath next values: latch on grant, count down, capture data.
    always_comb begin
        last_d  = last_q;
        id_d    = id_q;
        addr_d  = addr_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    last_d = gnt_id;
                    id_d   = gnt_id;
                    addr_d = req_addr[int'(gnt_id)*ADDR_W +: ADDR_W];
                end
            end
            ISSUE: cnt_d = CNT_W'(MEM_LAT - 1);
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    rdata_d = ins_data;
                end
            end
            RESP: ;
        endcase
    end

    // Outputs.
    always_comb begin
        resp_valid = '0;
        ins_read   = (state_q == ISSUE) || (state_q == WAIT);
        busy       = (state_q != IDLE);
        // A core disabled while its fetch was in flight gets no pulse.
        if (state_q == RESP) begin
            resp_valid[id_q] = core_en[id_q];
        end
    end

    assign ins_addr  = addr_q;
    assign resp_data = rdata_q;
    assign grant_id  = id_q;

endmodule

// File: tb/tb_im_fetch_arbiter.sv
// Bench for im_fetch_arbiter: two instances (MEM_LAT 1 and 3) share stimulus
// and are compared every cycle against a transaction-phase model.
module tb_im_fetch_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  core_en;
    logic [3:0]  req;
    logic [63:0] req_addr;

    logic [15:0] ins_addr   [2];
    logic        ins_read   [2];
    logic [15:0] ins_data   [2];
    logic [3:0]  resp_valid [2];
    logic [15:0] resp_data  [2];
    logic [1:0]  grant_id   [2];
    logic        busy       [2];
    int          rd_age     [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    im_fetch_arbiter #(.MEM_LAT(1)) u_dut0 (
        .clk(clk), .reset(reset), .core_en(core_en), .req(req),
        .req_addr(req_addr), .ins_addr(ins_addr[0]),
        .ins_read(ins_read[0]), .ins_data(ins_data[0]),
        .resp_valid(resp_valid[0]), .resp_data(resp_data[0]),
        .grant_id(grant_id[0]), .busy(busy[0])
    );

    im_fetch_arbiter #(.MEM_LAT(3)) u_dut1 (
        .clk(clk), .reset(reset), .core_en(core_en), .req(req),
        .req_addr(req_addr), .ins_addr(ins_addr[1]),
        .ins_read(ins_read[1]), .ins_data(ins_data[1]),
        .resp_valid(resp_valid[1]), .resp_data(resp_data[1]),
        .grant_id(grant_id[1]), .busy(busy[1])
    );

    function automatic int lat(int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic logic [15:0] ram(logic [15:0] a);
        return a ^ 16'hA5E5;
    endfunction

    // RAM model: correct word only exactly MEM_LAT cycles into a read.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            rd_age[d] <= ins_read[d] ? rd_age[d] + 1 : 0;
        end
    end

    assign ins_data[0] = (ins_read[0] && rd_age[0] == lat(0)) ?
                         ram(ins_addr[0]) : ~ram(ins_addr[0]);
    assign ins_data[1] = (ins_read[1] && rd_age[1] == lat(1)) ?
                         ram(ins_addr[1]) : ~ram(ins_addr[1]);

    // Model: a transaction is a phase count p after the grant edge;
    // p=0 issue, p=1..L waiting, p=L+1 response.
    bit          m_act   [2];
    int          m_p     [2];
    int          m_gid   [2];
    int          m_last  [2];
    logic [15:0] m_gaddr [2];
    logic [15:0] m_rdata [2];

    task automatic model_step();
        logic [3:0] elig;
        bit         found;
        int         idx;
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                m_act[d] = 0;  m_p[d] = 0;  m_gid[d] = 0;
                m_last[d] = 3; m_gaddr[d] = 0; m_rdata[d] = 0;
            end else if (!m_act[d]) begin
                elig  = req & core_en;
                found = 0;
                for (int k = 1; k <= 4; k++) begin
                    idx = (m_last[d] + k) % 4;
                    if (!found && elig[idx]) begin
                        found      = 1;
                        m_gid[d]   = idx;
                        m_last[d]  = idx;
                        m_gaddr[d] = req_addr[idx*16 +: 16];
                        m_act[d]   = 1;
                        m_p[d]     = 0;
                    end
                end
            end else begin
                if (m_p[d] == lat(d)) m_rdata[d] = ram(m_gaddr[d]);
                if (m_p[d] == lat(d) + 1) m_act[d] = 0;
                else m_p[d]++;
            end
        end
    endtask

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic compare_all();
        logic [3:0] erv;
        for (int d = 0; d < 2; d++) begin
            erv = '0;
            if (m_act[d] && m_p[d] == lat(d) + 1 && core_en[m_gid[d]])
                erv[m_gid[d]] = 1'b1;
            chk($sformatf("d%0d ins_read", d), 32'(ins_read[d]),
                32'(m_act[d] && m_p[d] <= lat(d)));
            chk($sformatf("d%0d ins_addr", d), 32'(ins_addr[d]),
                32'(m_gaddr[d]));
            chk($sformatf("d%0d resp_valid", d), 32'(resp_valid[d]),
                32'(erv));
            chk($sformatf("d%0d resp_data", d), 32'(resp_data[d]),
                32'(m_rdata[d]));
            chk($sformatf("d%0d grant_id", d), 32'(grant_id[d]),
                32'(m_gid[d]));
            chk($sformatf("d%0d busy", d), 32'(busy[d]), 32'(m_act[d]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        logic [3:0] s0[$];
        logic [3:0] s1[$];
        bit         found;

        reset = 1'b1; core_en = 4'h0; req = 4'h0; req_addr = '0;
        step();
        step();
        for (int d = 0; d < 2; d++) begin
            chk("reset busy", 32'(busy[d]), 0);
            chk("reset ins_read", 32'(ins_read[d]), 0);
            chk("reset grant_id", 32'(grant_id[d]), 0);
            chk("reset resp_data", 32'(resp_data[d]), 0);
        end
        reset = 1'b0;

        // Single fetch from core 2, both latencies.
        core_en  = 4'hF;
        req      = 4'b0100;
        req_addr = 64'h1111_0040_2222_3333;
        step();
        chk("t1 issue read", 32'(ins_read[0]), 1);
        chk("t1 issue addr", 32'(ins_addr[0]), 32'h0040);
        chk("t6 issue read", 32'(ins_read[1]), 1);
        for (int k = 1; k <= 4; k++) begin
            step();
            if (k == 2) begin
                chk("t1 resp_valid", 32'(resp_valid[0]), 32'h4);
                chk("t1 resp_data", 32'(resp_data[0]), 32'hA5A5);
                req = 4'b0000;
            end
            if (k <= 3) chk("t6 read held", 32'(ins_read[1]), 1);
            if (k == 3) chk("t6 no early resp", 32'(resp_valid[1]), 0);
            if (k == 4) begin
                chk("t6 resp_valid", 32'(resp_valid[1]), 32'h4);
                chk("t6 resp_data", 32'(resp_data[1]), 32'hA5A5);
                chk("t6 read off", 32'(ins_read[1]), 0);
            end
        end
        step();
        step();

        // Fairness after reset: each core drops after its response.
        do_reset();
        req = 4'hF;
        for (int c = 0; c < 24; c++) begin
            step();
            if (resp_valid[0] != 0) begin
                s0.push_back(resp_valid[0]);
                req = req & ~resp_valid[0];
            end
        end
        chk("t2 pulses", 32'(s0.size()), 4);
        foreach (s0[i]) chk("t2 order", 32'(s0[i]), 32'(1 << i));

        // Two persistent requesters alternate.
        do_reset();
        s0.delete();
        req = 4'b1001;
        for (int c = 0; c < 40; c++) begin
            step();
            if (resp_valid[0] != 0 && s0.size() < 4) s0.push_back(resp_valid[0]);
            if (resp_valid[1] != 0 && s1.size() < 4) s1.push_back(resp_valid[1]);
        end
        chk("t3 d0 count", 32'(s0.size()), 4);
        chk("t3 d1 count", 32'(s1.size()), 4);
        foreach (s0[i]) chk("t3 d0 order", 32'(s0[i]), (i % 2) ? 32'h8 : 32'h1);
        foreach (s1[i]) chk("t3 d1 order", 32'(s1[i]), (i % 2) ? 32'h8 : 32'h1);
        req = 4'h0;

        // Masking, then drop core 2's enable during its wait.
        do_reset();
        core_en = 4'b0101;
        req     = 4'hF;
        found   = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            step();
            if (busy[0] && grant_id[0] == 2'd2) found = 1;
        end
        chk("t4 core2 granted", 32'(found), 1);
        if (found) begin
            step();
            core_en = 4'b0001;
            step();
            chk("t4 dropped resp", 32'(resp_valid[0]), 0);
            chk("t4 still busy", 32'(busy[0]), 1);
            step();
            chk("t4 back idle", 32'(busy[0]), 0);
        end

        // Reset while core 1 is waiting.
        do_reset();
        core_en = 4'hF;
        req     = 4'hF;
        for (int c = 0; c < 6; c++) step();
        chk("t5 pre grant", 32'(grant_id[0]), 1);
        chk("t5 pre read", 32'(ins_read[0]), 1);
        reset = 1'b1;
        step();
        chk("t5 read off", 32'(ins_read[0]), 0);
        chk("t5 no resp", 32'(resp_valid[0]), 0);
        chk("t5 idle", 32'(busy[0]), 0);
        reset = 1'b0;
        step();
        chk("t5 first grant", 32'(grant_id[0]), 0);
        chk("t5 issue", 32'(ins_read[0]), 1);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            core_en  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            req      = 4'($urandom);
            req_addr = {$urandom, $urandom};
            reset    = ($urandom_range(0, 199) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
